// File: rtl/cplx_bfp_scale_if.sv
// Sample bus for the complex block-floating-point scaler: input sample, mode
// controls and the scaled output with its frame exponent and frame marker.
interface cplx_bfp_scale_if #(
  parameter int unsigned WL = 16,
  parameter int unsigned SW = 2
);
  logic          in_valid;
  logic [WL-1:0] in_r;
  logic [WL-1:0] in_i;
  logic          mode;
  logic [SW-1:0] fixed_shift;
  logic          out_valid;
  logic [WL-1:0] out_r;
  logic [WL-1:0] out_i;
  logic [SW-1:0] out_shift;
  logic          out_last;

  modport master (
    output in_valid, in_r, in_i, mode, fixed_shift,
    input  out_valid, out_r, out_i, out_shift, out_last
  );

  modport slave (
    input  in_valid, in_r, in_i, mode, fixed_shift,
    output out_valid, out_r, out_i, out_shift, out_last
  );
endinterface

// File: rtl/cplx_bfp_scale.sv
// Registered complex down-scaler with per-frame shift. Mode 0 applies a fixed
// (clamped) shift; mode 1 applies the shift derived from the previous frame's
// headroom. Three register stages: capture, rounding offset, shift/output.
module cplx_bfp_scale #(
  parameter int unsigned WL        = 16,
  parameter int unsigned MAX_SHIFT = 3,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ROUND     = 1
) (
  input logic             clk,
  input logic             rst,
  cplx_bfp_scale_if.slave bus
);
  localparam int unsigned SW = $clog2(MAX_SHIFT + 1);
  localparam int unsigned CW = $clog2(FRAME_LEN);
  localparam int unsigned GB = MAX_SHIFT + 1;
  localparam int unsigned XW = WL + 1;
  localparam logic [SW-1:0] SMAX  = SW'(MAX_SHIFT);
  localparam logic [CW-1:0] CLAST = CW'(FRAME_LEN - 1);

  // Smallest shift leaving GB equal sign bits at the top of the word.
  function automatic logic [SW-1:0] need_of(input logic [WL-1:0] x);
    logic [WL-1:0] y;
    logic [SW-1:0] n;
    n = SMAX;
    for (int s = int'(MAX_SHIFT); s >= 0; s--) begin
      y = WL'($signed(x) >>> s);
      if ((&y[WL-1 -: GB]) || !(|y[WL-1 -: GB])) n = SW'(s);
    end
    return n;
  endfunction

  logic [CW-1:0]        count;
  logic [SW-1:0]        frame_shift, next_shift, run_max;
  logic [SW-1:0]        fix_clamp, sel_shift, need_re, need_im, smp_need, run_need;
  logic                 v1, last1, v2, last2;
  logic [WL-1:0]        r1, i1;
  logic [SW-1:0]        sh1, sh2;
  logic signed [XW-1:0] r2, i2, rnd, sum_r, sum_i;
  logic [WL-1:0]        shr_r, shr_i;

  // Shift for the current sample and its headroom contribution
  always_comb begin
    fix_clamp = (32'(bus.fixed_shift) > MAX_SHIFT) ? SMAX : bus.fixed_shift;
    sel_shift = frame_shift;
    if (count == '0) sel_shift = bus.mode ? next_shift : fix_clamp;
    need_re  = need_of(bus.in_r);
    need_im  = need_of(bus.in_i);
    smp_need = (need_im > need_re) ? need_im : need_re;
    run_need = (smp_need > run_max) ? smp_need : run_max;
  end

  // Rounding offset, widened add and final arithmetic shift
  always_comb begin
    rnd = '0;
    if (ROUND != 0 && sh1 != '0) rnd = XW'(1) << (sh1 - SW'(1));
    sum_r = $signed({r1[WL-1], r1}) + rnd;
    sum_i = $signed({i1[WL-1], i1}) + rnd;
    shr_r = WL'(r2 >>> sh2);
    shr_i = WL'(i2 >>> sh2);
  end

  // Frame counter, latched frame shift and running headroom maximum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      frame_shift <= SMAX;
      next_shift  <= SMAX;
      run_max     <= '0;
    end else if (bus.in_valid) begin
      frame_shift <= sel_shift;
      if (count == CLAST) begin
        count      <= '0;
        next_shift <= run_need;
        run_max    <= '0;
      end else begin
        count   <= count + CW'(1);
        run_max <= run_need;
      end
    end
  end

  // Stage 1: capture sample with its frame shift and end-of-frame flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      r1    <= '0;
      i1    <= '0;
      sh1   <= '0;
      last1 <= 1'b0;
    end else begin
      v1    <= bus.in_valid;
      r1    <= bus.in_r;
      i1    <= bus.in_i;
      sh1   <= sel_shift;
      last1 <= bus.in_valid && (count == CLAST);
    end
  end

  // Stage 2: add the rounding offset at WL+1 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      r2    <= '0;
      i2    <= '0;
      sh2   <= '0;
      last2 <= 1'b0;
    end else begin
      v2    <= v1;
      r2    <= sum_r;
      i2    <= sum_i;
      sh2   <= sh1;
      last2 <= last1;
    end
  end

  // Output stage: shifted result, exponent and frame marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_r     <= '0;
      bus.out_i     <= '0;
      bus.out_shift <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      bus.out_valid <= v2;
      bus.out_r     <= shr_r;
      bus.out_i     <= shr_i;
      bus.out_shift <= sh2;
      bus.out_last  <= v2 && last2;
    end
  end
endmodule

// File: tb/tb_cplx_bfp_scale.sv
// Bench for cplx_bfp_scale: frame-level behavioural model with scoreboard,
// directed literal checks, framing with gaps and a randomized run. A second
// instance with ROUND=0 shares the same stimulus.
module tb_cplx_bfp_scale;
  localparam int WL = 16;
  localparam int MS = 3;
  localparam int FL = 16;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cplx_bfp_scale_if #(.WL(WL), .SW(SW)) bus ();
  cplx_bfp_scale_if #(.WL(WL), .SW(SW)) bus0 ();

  assign bus0.in_valid    = bus.in_valid;
  assign bus0.in_r        = bus.in_r;
  assign bus0.in_i        = bus.in_i;
  assign bus0.mode        = bus.mode;
  assign bus0.fixed_shift = bus.fixed_shift;

  cplx_bfp_scale #(.WL(WL), .MAX_SHIFT(MS), .FRAME_LEN(FL), .ROUND(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  cplx_bfp_scale #(.WL(WL), .MAX_SHIFT(MS), .FRAME_LEN(FL), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  typedef struct {
    int          due;
    logic [15:0] r1, i1, r0, i0;
    logic [1:0]  sh;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   lasts[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, nout = 0;
  int   pos = 0, cur_s = 0, nxt = MS, fmax = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
    end
  endtask

  // Headroom from the range a value must fall in after shifting
  function automatic int need_m(input int x);
    for (int s = 0; s <= MS; s++) begin
      int y = x >>> s;
      if (y >= -(1 << (WL - 1 - MS)) && y < (1 << (WL - 1 - MS))) return s;
    end
    return MS;
  endfunction

  function automatic logic [15:0] scale_m(input int x, input int s, input int rnd);
    int y = x;
    if (rnd != 0 && s > 0) y = y + (1 << (s - 1));
    y = y >>> s;
    return 16'(y);
  endfunction

  // Reference model: frame bookkeeping on each accepted sample
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      pos = 0; nxt = MS; fmax = 0; cur_s = 0;
    end else if (bus.in_valid) begin
      exp_t e;
      int xr, xi, n;
      xr = int'($signed(bus.in_r));
      xi = int'($signed(bus.in_i));
      if (pos == 0)
        cur_s = bus.mode ? nxt : ((int'(bus.fixed_shift) > MS) ? MS : int'(bus.fixed_shift));
      n = (need_m(xr) > need_m(xi)) ? need_m(xr) : need_m(xi);
      if (n > fmax) fmax = n;
      e.due  = cyc + 2;
      e.r1   = scale_m(xr, cur_s, 1);
      e.i1   = scale_m(xi, cur_s, 1);
      e.r0   = scale_m(xr, cur_s, 0);
      e.i0   = scale_m(xi, cur_s, 0);
      e.sh   = 2'(cur_s);
      e.last = (pos == FL - 1);
      q.push_back(e);
      if (pos == FL - 1) begin
        nxt = fmax; fmax = 0; pos = 0;
      end else begin
        pos++;
      end
    end
  end

  // Compare DUT outputs against the model every cycle out of reset
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      bit ev;
      while (q.size() > 0 && q[0].due < cyc) q.delete(0);
      ev = (q.size() > 0 && q[0].due == cyc);
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      chk("out_valid_r0", 64'(bus0.out_valid), 64'(ev));
      if (ev) begin
        e = q[0];
        q.delete(0);
        chk("sample_round", 64'({bus.out_r, bus.out_i, bus.out_shift, bus.out_last}),
            64'({e.r1, e.i1, e.sh, e.last}));
        chk("sample_trunc", 64'({bus0.out_r, bus0.out_i, bus0.out_shift, bus0.out_last}),
            64'({e.r0, e.i0, e.sh, e.last}));
      end
      if (bus.out_valid) begin
        if (bus.out_last) lasts.push_back(nout);
        nout++;
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] r, input logic [15:0] i,
                       input logic m, input logic [1:0] fs);
    @(negedge clk);
    #1;
    bus.in_valid    = v;
    bus.in_r        = r;
    bus.in_i        = i;
    bus.mode        = m;
    bus.fixed_shift = fs;
  endtask

  // One sample, then wait until its output is visible
  task automatic send_one(input logic [15:0] r, input logic [15:0] i,
                          input logic m, input logic [1:0] fs);
    drive(1'b1, r, i, m, fs);
    drive(1'b0, r, i, m, fs);
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [15:0] val, input int k,
                            input logic [15:0] kr, input logic [15:0] ki, input logic m);
    for (int j = 0; j < n; j++)
      drive(1'b1, (j == k) ? kr : val, (j == k) ? ki : val, m, 2'd0);
  endtask

  function automatic logic [15:0] rnd_val();
    logic [15:0] v;
    int sh;
    v  = 16'($urandom);
    sh = $urandom_range(0, 8);
    if ($urandom_range(0, 15) == 0) return ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
    return 16'($signed(v) >>> sh);
  endfunction

  task automatic do_reset();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic m;
    logic [1:0] fs;
    int n0;
    bus.in_valid = 1'b0; bus.in_r = '0; bus.in_i = '0; bus.mode = 1'b0; bus.fixed_shift = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_r", 64'(bus.out_r), 64'(0));
    chk("rst_i", 64'(bus.out_i), 64'(0));
    chk("rst_shift", 64'(bus.out_shift), 64'(0));
    chk("rst_last", 64'(bus.out_last), 64'(0));
    rst = 1'b0;

    // Fixed shift 2 with and without rounding
    send_one(16'd6, 16'hFFFB, 1'b0, 2'd2);
    chk("fix_r_rnd", 64'(bus.out_r), 64'(16'h0002));
    chk("fix_i_rnd", 64'(bus.out_i), 64'(16'hFFFF));
    chk("fix_shift", 64'(bus.out_shift), 64'(2));
    chk("fix_r_trunc", 64'(bus0.out_r), 64'(16'h0001));
    chk("fix_i_trunc", 64'(bus0.out_i), 64'(16'hFFFE));
    send_one(16'h7FFF, 16'h0000, 1'b0, 2'd2);
    chk("fix_max_rnd", 64'(bus.out_r), 64'(16'h2000));
    // Mid-frame change of fixed_shift must not take effect
    send_one(16'h0234, 16'hFFF9, 1'b0, 2'd0);
    chk("midframe_shift", 64'(bus.out_shift), 64'(2));
    send_frame(13, 16'h0100, -1, 16'h0, 16'h0, 1'b0);
    // Next frame: bypass with shift 0
    send_one(16'h0234, 16'hFFF9, 1'b0, 2'd0);
    chk("bypass_r", 64'(bus.out_r), 64'(16'h0234));
    chk("bypass_i", 64'(bus.out_i), 64'(16'hFFF9));
    chk("bypass_shift", 64'(bus.out_shift), 64'(0));
    send_frame(15, 16'h0100, -1, 16'h0, 16'h0, 1'b0);

    // Adaptive chain
    send_one(16'h0100, 16'h0100, 1'b1, 2'd0);
    chk("bfp_quiet_shift", 64'(bus.out_shift), 64'(0));
    send_frame(15, 16'h0100, 5, 16'h0100, 16'h1000, 1'b1);
    send_one(16'h0100, 16'h0100, 1'b1, 2'd0);
    chk("bfp_need1_shift", 64'(bus.out_shift), 64'(1));
    chk("bfp_need1_r", 64'(bus.out_r), 64'(16'h0080));
    send_frame(15, 16'h0100, 3, 16'h8000, 16'h0100, 1'b1);
    send_one(16'h0800, 16'h0800, 1'b1, 2'd0);
    chk("bfp_need3_shift", 64'(bus.out_shift), 64'(3));
    chk("bfp_need3_r", 64'(bus.out_r), 64'(16'h0100));
    send_frame(15, 16'h0800, -1, 16'h0, 16'h0, 1'b1);
    send_one(16'h0800, 16'h0800, 1'b1, 2'd0);
    chk("bfp_need0_shift", 64'(bus.out_shift), 64'(0));
    chk("bfp_need0_r", 64'(bus.out_r), 64'(16'h0800));

    // Reset mid-stream with valid high
    for (int j = 0; j < 4; j++) drive(1'b1, rnd_val(), rnd_val(), 1'b1, 2'd0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_r", 64'(bus.out_r), 64'(0));
    chk("midrst_i", 64'(bus.out_i), 64'(0));
    chk("midrst_shift", 64'(bus.out_shift), 64'(0));
    chk("midrst_last", 64'(bus.out_last), 64'(0));
    do_reset();
    send_one(16'h0100, 16'h0100, 1'b1, 2'd0);
    chk("post_rst_shift", 64'(bus.out_shift), 64'(3));
    chk("post_rst_r", 64'(bus.out_r), 64'(16'h0020));

    // Framing with random gaps from a fresh frame
    do_reset();
    n0 = nout;
    lasts.delete();
    for (int j = 0; j < 40; j++) begin
      while ($urandom_range(0, 2) == 0) drive(1'b0, 16'h0, 16'h0, 1'b0, 2'd1);
      drive(1'b1, rnd_val(), rnd_val(), 1'b0, 2'd1);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 2'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("frame_count", 64'(nout - n0), 64'(40));
    chk("frame_nlast", 64'(lasts.size()), 64'(2));
    if (lasts.size() == 2) begin
      chk("frame_last0", 64'(lasts[0] - n0), 64'(15));
      chk("frame_last1", 64'(lasts[1] - n0), 64'(31));
    end

    // Randomized run
    m = 1'b1;
    fs = 2'd0;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, rnd_val(), rnd_val(), m, fs);
      if ($urandom_range(0, 7) == 0) begin
        m  = 1'($urandom);
        fs = 2'($urandom);
      end
      drive(1'b1, rnd_val(), rnd_val(), m, fs);
    end
    drive(1'b0, 16'h0, 16'h0, m, fs);
    repeat (5) @(negedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
